boot_seq_loader: RTL

BOOT_SEQ_LOADER -- requirements
Module: boot_seq_loader

---
 rtl/boot_seq_pkg.sv | 12 +
 rtl/boot_seq_loader_ce_divider.sv | 16 +
 rtl/boot_seq_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared state encoding and limits for the boot sequence loader.
package boot_seq_pkg;
    localparam int MAX_SEG = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_EXEC
    } state_t;
endpackage

// File: rtl/boot_seq_loader_ce_divider.sv
// ce_divider: free-running modulo-DIV counter; tick is high while the count is zero.
module ce_divider #(
    parameter int DIV = 16
) (
    input  logic clk_sys,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
    end
    assign tick = (cnt == '0);
endmodule

// File: rtl/boot_seq_loader.sv
// boot_seq_loader: copies up to NUM_SEG ROM segments to a paced byte sink, then pulses execute.
module boot_seq_loader
    import boot_seq_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int ROM_AW     = 12,
    parameter int DATA_W     = 8,
    parameter int NUM_SEG    = 2,
    parameter int CE_DIV     = 16,
    parameter int AUTO_START = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_SEG*ROM_AW-1:0] seg_src,
    input  logic [NUM_SEG*ADDR_W-1:0] seg_dst,
    input  logic [NUM_SEG*ROM_AW-1:0] seg_len,
    input  logic [ADDR_W-1:0]         exec_addr_in,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      dn_go,
    output logic                      dn_wr,
    output logic [ADDR_W-1:0]         dn_addr,
    output logic [DATA_W-1:0]         dn_data,
    input  logic                      dn_wait,
    output logic                      execute_enable,
    output logic [ADDR_W-1:0]         execute_addr,
    output logic                      busy,
    output logic [2:0]                seg_idx
);
    localparam int SRC_W = MAX_SEG * ROM_AW;
    localparam int DST_W = MAX_SEG * ADDR_W;
    localparam logic [2:0] LAST = 3'(NUM_SEG - 1);

    state_t state, state_nxt;
    logic ce_tick, boot_pending, do_start, seg_adv, off_inc;
    logic [SRC_W-1:0] src_q, len_q;
    logic [DST_W-1:0] dst_q;
    logic [ROM_AW-1:0] cur_src, cur_len, off, off_nxt;
    logic [ADDR_W-1:0] cur_dst;

    ce_divider #(.DIV(CE_DIV)) u_ce (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .tick   (ce_tick)
    );

    // Descriptor tables are padded to MAX_SEG so the 3-bit index always selects in range.
    assign cur_src = src_q[int'(seg_idx) * ROM_AW +: ROM_AW];
    assign cur_len = len_q[int'(seg_idx) * ROM_AW +: ROM_AW];
    assign cur_dst = dst_q[int'(seg_idx) * ADDR_W +: ADDR_W];
    assign off_nxt = off + ROM_AW'(1);
    assign rom_addr = cur_src + off;
    assign dn_addr = cur_dst + ADDR_W'(off);
    assign dn_go = state inside {S_FETCH, S_LATCH, S_WRITE};
    assign busy = (state != S_IDLE);
    assign execute_enable = (state == S_EXEC) && !abort;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start = 1'b0;
        seg_adv = 1'b0;
        off_inc = 1'b0;
        dn_wr = 1'b0;
        case (state)
            S_IDLE: begin
                do_start = !abort && (start || boot_pending);
                state_nxt = do_start ? S_SEL : S_IDLE;
            end
            S_SEL: begin
                seg_adv = (cur_len == '0) && (seg_idx != LAST);
                state_nxt = (cur_len != '0) ? S_FETCH : (seg_idx == LAST) ? S_EXEC : S_SEL;
            end
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_WRITE;
            S_WRITE: begin
                dn_wr = ce_tick && !dn_wait;
                seg_adv = dn_wr && (off_nxt == cur_len) && (seg_idx != LAST);
                off_inc = dn_wr && (off_nxt != cur_len);
                state_nxt = !dn_wr ? S_WRITE : off_inc ? S_FETCH : (seg_idx == LAST) ? S_EXEC : S_SEL;
            end
            S_EXEC: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            boot_pending <= (AUTO_START != 0);
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            seg_idx <= '0;
            off <= '0;
            dn_data <= '0;
            execute_addr <= '0;
        end else begin
            boot_pending <= 1'b0;
            if (do_start) begin
                src_q <= SRC_W'(seg_src);
                dst_q <= DST_W'(seg_dst);
                len_q <= SRC_W'(seg_len);
                seg_idx <= '0;
                off <= '0;
                execute_addr <= exec_addr_in;
            end else if (seg_adv) begin
                seg_idx <= seg_idx + 3'd1;
                off <= '0;
            end else if (off_inc) begin
                off <= off_nxt;
            end
            if (state == S_LATCH) dn_data <= rom_data;
        end
    end
endmodule
